// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, beat count
// and the big-endian byte lane helper.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_LAST   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int BEATS      = 4;

    // Lane 0 is the most significant byte, so it lands at the lowest address.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[31 - 8*int'(k) -: 8];
    endfunction

endpackage

// File: rtl/dmem_arbiter_byte_ram.sv
// Single-ported byte-wide storage with a registered read (1-cycle latency).
module byte_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one byte RAM between two word requesters;
// each word is moved as four big-endian byte beats, after a zero-clear on reset.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        busy,
    output logic        init_done
);

    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [1:0]        LAST_BEAT   = 2'(BEATS - 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] init_cnt;
    logic [1:0]        beat;
    logic              grant, last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [23:0]       asm_q;

    logic              arb_valid, arb_port;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_rdata;
    logic              ack0_d, ack1_d, rd_load, busy_d, init_done_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

    // On a tie the port not granted last wins; otherwise the lone requester.
    assign arb_valid = m0_req | m1_req;
    assign arb_port  = (m0_req && m1_req) ? ~last_grant : m1_req;

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= RESET_STATE;
            init_cnt   <= '0;
            beat       <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            asm_q      <= '0;
        end else begin
            state    <= next_state;
            init_cnt <= (state == ST_INIT) ? init_cnt + ADDR_W'(1) : '0;
            beat     <= (state == ST_ACCESS) ? beat + 2'd1 : 2'd0;
            if (state == ST_IDLE && arb_valid) begin
                grant      <= arb_port;
                last_grant <= arb_port;
                lat_we     <= arb_port ? m1_we : m0_we;
                lat_addr   <= arb_port ? m1_addr[ADDR_W-1:0] : m0_addr[ADDR_W-1:0];
                lat_wdata  <= arb_port ? m1_wdata : m0_wdata;
            end
            // Read data trails the issuing beat by one cycle.
            if (state == ST_ACCESS && beat != 2'd0) begin
                asm_q <= {asm_q[15:0], ram_rdata};
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:   if (init_cnt == LAST_ADDR) next_state = ST_IDLE;
            ST_IDLE:   if (arb_valid) next_state = ST_ACCESS;
            ST_ACCESS: if (beat == LAST_BEAT) next_state = lat_we ? ST_ACK : ST_LAST;
            ST_LAST:   next_state = ST_ACK;
            ST_ACK:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_we      = 1'b0;
        ram_addr    = lat_addr + ADDR_W'(beat);
        ram_wdata   = byte_lane(lat_wdata, beat);
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_addr  = init_cnt;
            ram_wdata = 8'h00;
        end else if (state == ST_ACCESS) begin
            ram_we    = lat_we;
        end
        ack0_d      = (next_state == ST_ACK) && (state != ST_ACK) && !grant;
        ack1_d      = (next_state == ST_ACK) && (state != ST_ACK) && grant;
        rd_load     = (state == ST_LAST);
        busy_d      = (next_state != ST_IDLE);
        init_done_d = init_done || !CLEAR_ON_RESET ||
                      (state == ST_INIT && next_state == ST_IDLE);
    end

    // Outputs are registered from next-cycle values so they line up with the state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            busy      <= (RESET_STATE != ST_IDLE);
            init_done <= 1'b0;
        end else begin
            m0_ack    <= ack0_d;
            m1_ack    <= ack1_d;
            busy      <= busy_d;
            init_done <= init_done_d;
            if (rd_load && !grant) m0_rdata <= {asm_q, ram_rdata};
            if (rd_load && grant)  m1_rdata <= {asm_q, ram_rdata};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized checks of dmem_arbiter against a byte-array memory model.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, busy, init_done;
    logic [31:0] m0_rdata, m1_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [0:255];
    logic [31:0] exp_rd [2];
    int          tb_last;

    dmem_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .busy(busy), .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) ref_mem[a[7:0] + 8'(k)] = 8'(d >> (24 - 8*k));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(ref_mem[a[7:0] + 8'(k)]);
        return w;
    endfunction

    function automatic logic get_ack(input int p);
        return (p == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One complete transaction on an otherwise idle arbiter.
    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int n = 0;
        bit got = 0;
        set_port(p, 1'b1, we, addr, wdata);
        while (!got && n < 40) begin
            @(posedge CLK); #1;
            n++;
            chk("other_ack", 32'(get_ack(1 - p)), 32'h0);
            if (get_ack(p)) got = 1;
        end
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("ack_latency", n, we ? 5 : 6);
        tb_last = p;
        if (we) model_write(addr, wdata);
        else    exp_rd[p] = model_read(addr);
        chk("rdata_granted", get_rdata(p), exp_rd[p]);
        chk("rdata_other", get_rdata(1 - p), exp_rd[1 - p]);
        @(posedge CLK); #1;
        chk("ack_width", 32'(get_ack(p)), 32'h0);
    endtask

    initial begin
        int          n, idle_n, ack_n, first;
        int          rem [2];
        logic [31:0] cur [2];
        logic [1:0]  acks, prev;
        int          order [$];
        logic [31:0] a;

        Reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_clear();
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        tb_last   = 1;

        // Reset values, then a request raised during the clear.
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack), 32'h0);
        chk("rst_m1_ack", 32'(m1_ack), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        n = 0; idle_n = -1; ack_n = -1;
        while (ack_n < 0 && n < 400) begin
            @(posedge CLK); #1;
            n++;
            if (n == 10) set_port(1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
            if (init_done && idle_n < 0) idle_n = n;
            if (m1_ack) ack_n = n;
        end
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("init_length", idle_n, 256);
        chk("init_req_latency", ack_n - idle_n, 5);
        model_write(32'h40, 32'hCAFEF00D);
        tb_last = 1;
        @(posedge CLK); #1;
        chk("init_req_ack_width", 32'(m1_ack), 32'h0);

        access(0, 1'b0, 32'h00, 32'h0);
        chk("cleared_word", m0_rdata, 32'h0);
        access(1, 1'b0, 32'h40, 32'h0);
        chk("init_req_data", m1_rdata, 32'hCAFEF00D);

        // Write/read and byte-offset peek.
        access(0, 1'b1, 32'h10, 32'h12345678);
        access(0, 1'b0, 32'h10, 32'h0);
        chk("wr_rd_0x10", m0_rdata, 32'h12345678);
        access(1, 1'b0, 32'h10, 32'h0);
        chk("peek_0x10", m1_rdata, 32'h12345678);
        access(1, 1'b0, 32'h13, 32'h0);
        chk("peek_0x13_msb", m1_rdata >> 24, 32'h78);

        // Address wrap across the top of memory.
        access(0, 1'b1, 32'hFE, 32'hAABBCCDD);
        access(0, 1'b0, 32'h00, 32'h0);
        chk("wrap_0x00", m0_rdata, 32'hCCDD0000);
        access(1, 1'b0, 32'hFFFF_FFFE, 32'h0);
        chk("wrap_0xFE", m1_rdata, 32'hAABBCCDD);

        // Contention: both ports hold two writes each.
        rem[0] = 2; rem[1] = 2;
        for (int p = 0; p < 2; p++) begin
            cur[p] = $urandom;
            set_port(p, 1'b1, 1'b1, 32'h80 + 32'(16*p), cur[p]);
        end
        n = 0; prev = 2'b00;
        while ((rem[0] > 0 || rem[1] > 0) && n < 100) begin
            @(posedge CLK); #1;
            n++;
            acks = {m1_ack, m0_ack};
            chk("dual_ack", 32'(acks == 2'b11), 32'h0);
            chk("contention_ack_width", 32'(prev & acks), 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (acks[p]) begin
                    order.push_back(p);
                    model_write(32'h80 + 32'(16*p + 4*(2 - rem[p])), cur[p]);
                    rem[p]--;
                    if (rem[p] > 0) begin
                        cur[p] = $urandom;
                        set_port(p, 1'b1, 1'b1, 32'h80 + 32'(16*p + 4*(2 - rem[p])), cur[p]);
                    end else begin
                        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end
            end
            prev = acks;
        end
        chk("contention_count", order.size(), 4);
        first = (tb_last == 1) ? 0 : 1;
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("contention_order", order[i], first ^ (i & 1));
        if (order.size() > 0) tb_last = order[order.size() - 1];
        @(posedge CLK); #1;
        chk("contention_idle_ack", 32'({m1_ack, m0_ack}), 32'h0);
        access(1, 1'b0, 32'h84, 32'h0);
        access(0, 1'b0, 32'h94, 32'h0);

        // Randomized traffic against the byte-array model.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[7:0] = 8'($urandom_range(0, 40));
            access($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset during beat 2 of a write.
        set_port(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk("abort_no_ack", 32'({m1_ack, m0_ack}), 32'h0);
        end
        Reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("abort_ack", 32'({m1_ack, m0_ack}), 32'h0);
        chk("abort_busy", 32'(busy), 32'h1);
        chk("abort_init_done", 32'(init_done), 32'h0);
        chk("abort_m0_rdata", m0_rdata, 32'h0);
        model_clear();
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        tb_last   = 1;
        n = 0;
        while (!init_done && n < 400) begin
            @(posedge CLK); #1;
            n++;
            chk("abort_init_no_ack", 32'({m1_ack, m0_ack}), 32'h0);
        end
        chk("reinit_length", n, 256);
        access(0, 1'b0, 32'h20, 32'h0);
        chk("abort_addr_cleared", m0_rdata, 32'h0);
        access(1, 1'b0, 32'h10, 32'h0);
        chk("old_data_cleared", m1_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
